// File: rtl/button_bank.sv
// Multi-channel push-button front end: synchronise, debounce, and emit
// press / release / long-press / auto-repeat single-cycle ticks per channel.

module button_bank_ch #(
    parameter int DEBOUNCE_CYCLES = 240_000,
    parameter int LONG_CYCLES     = 12_000_000,
    parameter int REPEAT_CYCLES   = 2_400_000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic repeat_en,
    output logic level,
    output logic press_tick,
    output logic release_tick,
    output logic long_tick,
    output logic repeat_tick
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [DW-1:0] DB_TC   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_TC = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_TC  = RW'(REPEAT_CYCLES - 1);
    localparam logic RELEASED = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    logic          sync1, sync2;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt, hold_d;
    logic [RW-1:0] rep_cnt, rep_d;
    state_t        state, state_d;
    logic          pressed, differ, accept, rise, fall;
    logic          press_d, release_d, long_d, repeat_d;

    // Ticks are decided from the debounce accept so they land in the same
    // cycle btn_level first shows the new value.
    always_comb begin
        pressed = sync2 ^ RELEASED;
        differ  = pressed != level;
        accept  = differ && (db_cnt == DB_TC);
        rise    = accept && pressed;
        fall    = accept && !pressed;
    end

    always_comb begin
        state_d   = state;
        hold_d    = hold_cnt;
        rep_d     = rep_cnt;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        unique case (state)
            IDLE: if (rise) begin
                state_d = HELD;
                hold_d  = '0;
                press_d = 1'b1;
            end
            HELD: if (fall) begin
                state_d   = IDLE;
                hold_d    = '0;
                release_d = 1'b1;
            end else if (hold_cnt == HOLD_TC) begin
                state_d = LONG;
                hold_d  = '0;
                rep_d   = '0;
                long_d  = 1'b1;
            end else begin
                hold_d = hold_cnt + HW'(1);
            end
            LONG: if (fall) begin
                state_d   = IDLE;
                rep_d     = '0;
                release_d = 1'b1;
            end else if (!repeat_en) begin
                rep_d = '0;
            end else if (rep_cnt == REP_TC) begin
                rep_d    = '0;
                repeat_d = 1'b1;
            end else begin
                rep_d = rep_cnt + RW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1        <= RELEASED;
            sync2        <= RELEASED;
            level        <= 1'b0;
            db_cnt       <= '0;
            state        <= IDLE;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            press_tick   <= 1'b0;
            release_tick <= 1'b0;
            long_tick    <= 1'b0;
            repeat_tick  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (!differ) begin
                db_cnt <= '0;
            end else if (accept) begin
                level  <= pressed;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
            state        <= state_d;
            hold_cnt     <= hold_d;
            rep_cnt      <= rep_d;
            press_tick   <= press_d;
            release_tick <= release_d;
            long_tick    <= long_d;
            repeat_tick  <= repeat_d;
        end
    end
endmodule

module button_bank #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 240_000,
    parameter int LONG_CYCLES     = 12_000_000,
    parameter int REPEAT_CYCLES   = 2_400_000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_tick,
    output logic [N_BTN-1:0] release_tick,
    output logic [N_BTN-1:0] long_tick,
    output logic [N_BTN-1:0] repeat_tick
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_bank_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .pin         (btn_in[i]),
            .repeat_en   (repeat_en),
            .level       (btn_level[i]),
            .press_tick  (press_tick[i]),
            .release_tick(release_tick[i]),
            .long_tick   (long_tick[i]),
            .repeat_tick (repeat_tick[i])
        );
    end
endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: per-cycle comparison of each channel's
// {level, press, release, long, repeat} against hand-computed cycle numbers.

module tb_button_bank;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_in;
    logic       repeat_en;
    logic [1:0] btn_level, press_tick, release_tick, long_tick, repeat_tick;
    int         errors = 0;
    int         checks = 0;

    button_bank #(
        .N_BTN(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20),
        .REPEAT_CYCLES(5), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .repeat_en(repeat_en),
        .btn_level(btn_level), .press_tick(press_tick),
        .release_tick(release_tick), .long_tick(long_tick),
        .repeat_tick(repeat_tick)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] obs(input int c);
        return {btn_level[c], press_tick[c], release_tick[c], long_tick[c], repeat_tick[c]};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; btn_in = 2'b11; repeat_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst_n = 1'b0; btn_in = 2'b10; repeat_en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            got = {btn_level, press_tick, release_tick, long_tick, repeat_tick};
            checks++;
            if (got !== 10'b0) begin
                errors++;
                $display("FAIL reset_hold k=%0d got=%b exp=%b", k, got, 10'b0);
            end
        end
        btn_in = 2'b11; rst_n = 1'b1; repeat_en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            got = {btn_level, press_tick, release_tick, long_tick, repeat_tick};
            checks++;
            if (got !== 10'b0) begin
                errors++;
                $display("FAIL reset_exit k=%0d got=%b exp=%b", k, got, 10'b0);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] got;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) begin
                btn_in[0] = (i == 3);
                step();
                got = obs(0);
                checks++;
                if (got !== 5'b0) begin
                    errors++;
                    $display("FAIL bounce r=%0d i=%0d got=%b exp=%b", r, i, got, 5'b0);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            step();
            got = obs(0);
            checks++;
            if (got !== 5'b0) begin
                errors++;
                $display("FAIL bounce_tail k=%0d got=%b exp=%b", k, got, 5'b0);
            end
        end
    endtask

    task automatic test_short_press();
        logic [4:0] got, exp;
        do_reset();
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 13) btn_in[0] = 1'b1;  // high after edge 12
            step();
            got = obs(0);
            exp = {(k >= 6 && k < 18), (k == 6), (k == 18), 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL short_press k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [4:0] got, exp;
        do_reset();
        repeat_en = 1'b1;
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 39) btn_in[0] = 1'b1;  // released after edge 38
            step();
            got = obs(0);
            exp = {(k >= 6 && k < 44), (k == 6), (k == 44), (k == 26),
                   (k == 31 || k == 36 || k == 41)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL long_repeat k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        repeat_en = 1'b0;
    endtask

    task automatic test_repeat_gating();
        logic [4:0] got, exp;
        do_reset();
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 65; k++) begin
            if (k == 37) repeat_en = 1'b1;  // set during cycle press+30
            if (k == 48) btn_in[0] = 1'b1;
            step();
            got = obs(0);
            exp = {(k >= 6 && k < 53), (k == 6), (k == 53), (k == 26),
                   (k == 41 || k == 46 || k == 51)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL repeat_gating k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        repeat_en = 1'b0;
    endtask

    task automatic test_release_at_tc();
        logic [4:0] got, exp;
        do_reset();
        repeat_en = 1'b1;
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 21) btn_in[0] = 1'b1;  // level falls exactly at press+20
            step();
            got = obs(0);
            exp = {(k >= 6 && k < 26), (k == 6), (k == 26), 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL release_at_tc k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        repeat_en = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] got0, got1, exp0, exp1;
        do_reset();
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            if (k == 11) btn_in[1] = 1'b0;
            if (k == 21) btn_in[1] = 1'b1;
            if (k == 31) rst_n = 1'b0;      // sampled at edge 31
            if (k == 32) rst_n = 1'b1;
            if (k == 34) btn_in[1] = 1'b0;
            if (k == 41) btn_in[1] = 1'b1;
            step();
            got0 = obs(0);
            got1 = obs(1);
            exp0 = {((k >= 6 && k < 31) || k >= 37), (k == 6 || k == 37), 1'b0,
                    (k == 26 || k == 57), 1'b0};
            exp1 = {((k >= 16 && k < 26) || (k >= 39 && k < 46)), (k == 16 || k == 39),
                    (k == 26 || k == 46), 1'b0, 1'b0};
            checks++;
            if (got0 !== exp0) begin
                errors++;
                $display("FAIL mid_hold_ch0 k=%0d got=%b exp=%b", k, got0, exp0);
            end
            checks++;
            if (got1 !== exp1) begin
                errors++;
                $display("FAIL mid_hold_ch1 k=%0d got=%b exp=%b", k, got1, exp1);
            end
        end
        btn_in = 2'b11;
    endtask

    initial begin
        rst_n = 1'b0; btn_in = 2'b11; repeat_en = 1'b0;
        test_reset();
        test_bounce();
        test_short_press();
        test_long_repeat();
        test_repeat_gating();
        test_release_at_tc();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/button_bank.md
# button_bank

Parametrised multi-channel push-button front end: per channel it synchronises the raw pin and debounces it over a configurable window. It then reports press, release, long-press and auto-repeat events as single-cycle ticks. It sits between the board button pins and the control FSMs, replacing per-button single-tick debouncers. All channels share one clock and are fully independent.

## Interface
- N_BTN, 4, number of button channels (>= 1)
- DEBOUNCE_CYCLES, 240_000, consecutive cycles the synchronised input must differ from the debounced level before it is accepted (20 ms @ 12 MHz; >= 1)
- LONG_CYCLES, 12_000_000, cycles of continuous debounced press before long_tick (1 s @ 12 MHz; >= 1)
- REPEAT_CYCLES, 2_400_000, auto-repeat period after long press (200 ms @ 12 MHz; >= 1)
- ACTIVE_LOW, 1, 1: pin low = pressed; 0: pin high = pressed
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active low
- btn_in  input  N_BTN  raw asynchronous button pins
- repeat_en  input  1  global enable for auto-repeat ticks
- btn_level  output  N_BTN  debounced state, 1 = pressed
- press_tick  output  N_BTN  1-cycle pulse on debounced press
- release_tick  output  N_BTN  1-cycle pulse on debounced release
- long_tick  output  N_BTN  1-cycle pulse when hold reaches LONG_CYCLES
- repeat_tick  output  N_BTN  1-cycle pulse every REPEAT_CYCLES while long-held and repeat_en=1

## Operation
- Per channel: 2-FF synchroniser, then polarity normalisation to pressed=1 (invert when ACTIVE_LOW=1).
- Debounce: counter clears in any cycle where the synchronised value equals btn_level. Otherwise it increments. The cycle it would reach DEBOUNCE_CYCLES, btn_level takes the new value and the counter clears. Width is $clog2(DEBOUNCE_CYCLES+1).
- Hold FSM per channel, states IDLE, HELD, LONG:
  - IDLE -> HELD on btn_level rise: press_tick, hold counter = 0.
  - HELD: hold counter +1 per cycle. When it reaches LONG_CYCLES: long_tick, -> LONG, repeat counter = 0.
  - LONG: while repeat_en=1, repeat counter +1 per cycle. When it reaches REPEAT_CYCLES: repeat_tick, counter = 0. While repeat_en=0, the repeat counter is held at 0.
  - HELD/LONG -> IDLE on btn_level fall: release_tick, counters cleared.
- Release wins over a coincident long/repeat terminal count: release_tick only, no long_tick or repeat_tick that cycle.
- Counter widths are $clog2(max+1) of their parameter. No counter wraps: each is cleared at its terminal count or on a state change.
- Reset (rst_n=0 at a clk edge): synchroniser FFs load the released pin level (1 if ACTIVE_LOW). All counters clear, all FSMs go to IDLE, and all outputs are 0. A button held through reset is re-debounced afterwards and produces a fresh press_tick; no spurious tick is emitted on reset exit.

## Timing
- Reset value of every output: 0.
- Pin change to btn_level: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles of stable differing input.
- press_tick / release_tick are high exactly in the first cycle btn_level shows the new value.
- long_tick is high LONG_CYCLES cycles after the press_tick cycle.
- The first repeat_tick is REPEAT_CYCLES cycles after long_tick, then every REPEAT_CYCLES cycles, provided repeat_en stays 1.
- If repeat_en rises mid-LONG, the first repeat_tick follows REPEAT_CYCLES cycles later.
- All ticks are registered and last exactly 1 cycle. At most one of press/release/long/repeat is high per channel per cycle.

## Test plan
Use N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, ACTIVE_LOW=1.
- Bounce rejection: btn_in[0] low for 3 cycles, then high, repeated 5 times -> btn_level, press_tick and release_tick stay 0.
- Clean short press: btn_in[0] low for 12 cycles, then high -> btn_level rises 6 cycles after the falling pin edge with press_tick pulsed that cycle. release_tick fires 6 cycles after the pin returns high. No long_tick.
- Long + repeat: btn_in[0] held low, repeat_en=1 -> long_tick at press_tick+20, repeat_tick at +25, +30, +35. On release: release_tick, no further ticks.
- Repeat gating: repeat_en=0 during hold -> long_tick only. Raise repeat_en at press_tick+30 -> first repeat_tick at +35.
- Release at terminal count: release so btn_level falls exactly at press_tick+20 -> release_tick only, no long_tick.
- Reset mid-hold + channel independence: ch1 pressed at random offsets while ch0 is long-held. Pulse rst_n=0 for 1 cycle -> all outputs 0 the next cycle. ch0 is still held, so press_tick[0] recurs 6 cycles after reset release. ch1 events are unaffected by ch0 activity.
